// File: rtl/shift_buffer_pkg.sv
// Shared constants and helpers for the stream line packer.
package shift_buffer_pkg;

    // Default geometry: 32-bit producer words packed eight to a line.
    localparam int DEF_IN_W  = 32;
    localparam int DEF_WORDS = 8;

    // Width of a field that must hold every value 0..words inclusive.
    function automatic int cnt_bits(input int words);
        return $clog2(words + 1);
    endfunction

    // Physical slot position for logical fill index k. In MSB-first order the
    // first word of a line sits in the top slot.
    function automatic int slot_pos(input int k, input int words, input bit msb_first);
        return msb_first ? (words - 1 - k) : k;
    endfunction

endpackage

// File: rtl/shift_buffer_out_reg.sv
// Valid/ready output register slice: loads a completed line, holds it under
// backpressure and drops valid once the line has been taken.
module shift_buffer_out_reg
    import shift_buffer_pkg::*;
#(
    parameter int LINE_W = DEF_IN_W * DEF_WORDS,
    parameter int CNT_W  = cnt_bits(DEF_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] line,
    input  logic [CNT_W-1:0]  count,
    input  logic              ready,
    output logic              valid,
    output logic [LINE_W-1:0] data,
    output logic [CNT_W-1:0]  line_count,
    output logic              free
);

    // The slice can take a new line when empty or when the held one leaves now.
    always_comb begin
        free = !valid || ready;
    end

    // Load on transfer; otherwise hold data/count stable and retire valid on ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            data       <= '0;
            line_count <= '0;
        end else if (load) begin
            valid      <= 1'b1;
            data       <= line;
            line_count <= count;
        end else if (ready) begin
            valid      <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_buffer_stream.sv
// Packs a stream of IN_W-bit words into WORDS-wide lines. A line leaves when
// it is full or has been closed by a flush; the next line starts filling in
// the same cycle, so a drained output sees no bubble between lines.
module shift_buffer_stream
    import shift_buffer_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int WORDS     = DEF_WORDS,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = cnt_bits(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [IN_W-1:0]       in_data_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [IN_W*WORDS-1:0] out_data_o,
    output logic [CNT_W-1:0]      out_count_o
);

    localparam int LINE_W = IN_W * WORDS;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(WORDS);

    cnt_t              cnt_q;
    logic              closed_q;
    logic [IN_W-1:0]   slot_q [WORDS];
    wire  [LINE_W-1:0] line;

    logic complete;
    logic out_free;
    logic in_ready;
    logic accept;
    logic transfer;
    cnt_t wr_idx;

    // Handshake decode. in_ready is combinational on out_ready_i through out_free.
    always_comb begin
        complete = (cnt_q == FULL_CNT) || closed_q;
        in_ready = !complete || out_free;
        accept   = in_valid_i && in_ready;
        transfer = complete && out_free;
        // A word accepted while the old line leaves opens the new line at slot 0.
        wr_idx   = transfer ? '0 : cnt_q;
    end

    assign in_ready_o = in_ready;

    // Fill count and close flag. A flush in a transfer cycle can only refer to
    // the new line, so it closes that line only if a word lands in it. Outside
    // a transfer, a complete line is stalled and further flushes are moot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            closed_q <= 1'b0;
        end else if (transfer) begin
            cnt_q    <= cnt_t'(accept);
            closed_q <= flush_i && accept;
        end else begin
            cnt_q <= cnt_q + cnt_t'(accept);
            if (flush_i && !complete && ((cnt_q != '0) || accept)) begin
                closed_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < WORDS; k++) begin : g_slot
        localparam int POS = slot_pos(k, WORDS, MSB_FIRST);

        // Each slot captures its word, or clears when its line is handed off
        // so partial lines always carry zeros in unwritten slots.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q[k] <= '0;
            end else if (accept && (wr_idx == cnt_t'(k))) begin
                slot_q[k] <= in_data_i;
            end else if (transfer) begin
                slot_q[k] <= '0;
            end
        end

        assign line[POS*IN_W +: IN_W] = slot_q[k];
    end

    shift_buffer_out_reg #(
        .LINE_W (LINE_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (transfer),
        .line       (line),
        .count      (cnt_q),
        .ready      (out_ready_i),
        .valid      (out_valid_o),
        .data       (out_data_o),
        .line_count (out_count_o),
        .free       (out_free)
    );

endmodule

// File: tb/tb_shift_buffer_stream.sv
// Directed bench for shift_buffer_stream: a cycle table for the basic and
// flush behaviour, plus sequences for streaming, backpressure, flush corner
// cases and an MSB-first instance with mid-line reset.
module tb_shift_buffer_stream;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [3:0]   out_count;

    logic         rst_m;
    logic         m_in_valid;
    logic         m_in_ready;
    logic [15:0]  m_in_data;
    logic         m_flush;
    logic         m_out_valid;
    logic         m_out_ready;
    logic [63:0]  m_out_data;
    logic [2:0]   m_out_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit ok;
    bit mon_en = 0;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         fl;
        logic         ordy;
        logic         irdy;
        logic         ov;
        logic [3:0]   cnt;
        logic [255:0] data;
    } vec_t;

    typedef struct {
        logic [255:0] data;
        logic [3:0]   cnt;
    } line_t;

    vec_t  vecs[$];
    line_t exp_q[$];
    line_t cur;
    int    hs_cyc[$];

    shift_buffer_stream dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_count_o (out_count)
    );

    shift_buffer_stream #(
        .IN_W      (16),
        .WORDS     (4),
        .MSB_FIRST (1'b1)
    ) dut_m (
        .clk         (clk),
        .rst         (rst_m),
        .in_valid_i  (m_in_valid),
        .in_ready_o  (m_in_ready),
        .in_data_i   (m_in_data),
        .flush_i     (m_flush),
        .out_valid_o (m_out_valid),
        .out_ready_i (m_out_ready),
        .out_data_o  (m_out_data),
        .out_count_o (m_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Line whose word k (LSB-first) is base+k for k < n, zeros above.
    function automatic logic [255:0] seq_line(input int base, input int n);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r = r | (256'(32'(base + k)) << (k * 32));
        end
        return r;
    endfunction

    function automatic vec_t mkv(input logic v, input int d, input logic fl, input logic irdy,
                                 input logic ov, input int cnt, input logic [255:0] data);
        vec_t r;
        r.v = v; r.d = 32'(d); r.fl = fl; r.ordy = 1'b1; r.irdy = irdy;
        r.ov = ov; r.cnt = 4'(cnt); r.data = data;
        return r;
    endfunction

    function automatic line_t mkl(input int base, input int n);
        line_t r;
        r.data = seq_line(base, n);
        r.cnt  = 4'(n);
        return r;
    endfunction

    // Offer one word, retrying up to budget cycles; called and returns at posedge+1.
    task automatic drive_word(input int d, input int budget, output bit acc_ok);
        bit acc;
        acc_ok   = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'(d);
        for (int c = 0; c < budget && !acc_ok; c++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            acc_ok = acc;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 256'(exp_q.size()), 256'(0));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every line handshake is compared against the expected queue.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line: got 0x%0h, want none", out_data);
            end else begin
                cur = exp_q.pop_front();
                chk("line_data", out_data, cur.data);
                chk("line_count", 256'(out_count), 256'(cur.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_m = 1'b1;
        in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
        m_in_valid = 0; m_in_data = 0; m_flush = 0; m_out_ready = 0;

        // Cycle table (out_ready high throughout).
        for (int i = 0; i < 8; i++) vecs.push_back(mkv(1, 10 + i, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 8, seq_line(10, 8)));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(1, 30, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(1, 31, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(1, 32, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(0, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mkv(1, 40, 0, 1, 1, 3, seq_line(30, 3)));
        vecs.push_back(mkv(0, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 1, seq_line(40, 1)));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(0, 0, 1, 1, 0, 0, '0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 0, '0));
        vecs.push_back(mkv(1, 50, 1, 1, 0, 0, '0));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 1, seq_line(50, 1)));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 0, '0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", 256'(out_count), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        rst = 1'b0; rst_m = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 256'(in_ready), 256'(vecs[i].irdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 256'(out_valid), 256'(vecs[i].ov));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_out_count", i), 256'(out_count), 256'(vecs[i].cnt));
                chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].data);
            end
        end
        idle(1);

        // Two back-to-back lines, drained output: no stall, lines 8 cycles apart.
        mon_en = 1;
        out_ready = 1;
        hs_cyc.delete();
        exp_q.push_back(mkl(10, 8));
        exp_q.push_back(mkl(20, 8));
        for (int w = 0; w < 16; w++) begin
            drive_word((w < 8) ? 10 + w : 12 + w, 1, ok);
            chk($sformatf("t2_in_ready_w%0d", w), 256'(ok), 256'(1));
        end
        in_valid = 0;
        wait_drain("t2_drain", 20);
        idle(3);
        chk("t2_line_count", 256'(hs_cyc.size()), 256'(2));
        if (hs_cyc.size() == 2) chk("t2_line_gap", 256'(hs_cyc[1] - hs_cyc[0]), 256'(8));

        // Backpressure: two lines fill, third word stream stalls at 26.
        out_ready = 0;
        hs_cyc.delete();
        exp_q.push_back(mkl(10, 8));
        exp_q.push_back(mkl(18, 8));
        exp_q.push_back(mkl(26, 8));
        for (int w = 10; w < 26; w++) begin
            drive_word(w, 4, ok);
            chk($sformatf("t3_accept_%0d", w), 256'(ok), 256'(1));
        end
        drive_word(26, 3, ok);
        chk("t3_stall", 256'(ok), 256'(0));
        chk("t3_hold_valid", 256'(out_valid), 256'(1));
        chk("t3_hold_count", 256'(out_count), 256'(8));
        chk("t3_hold_data", out_data, seq_line(10, 8));
        out_ready = 1;
        for (int w = 26; w < 34; w++) begin
            drive_word(w, 4, ok);
            chk($sformatf("t3_accept_%0d", w), 256'(ok), 256'(1));
        end
        in_valid = 0;
        wait_drain("t3_drain", 20);
        idle(3);
        chk("t3_lines", 256'(hs_cyc.size()), 256'(3));

        // Flush together with the 8th word: exactly one full line.
        hs_cyc.delete();
        exp_q.push_back(mkl(70, 8));
        for (int w = 70; w < 77; w++) drive_word(w, 2, ok);
        flush = 1;
        drive_word(77, 2, ok);
        chk("t5b_accept_last", 256'(ok), 256'(1));
        idle(12);
        chk("t5b_drain", 256'(exp_q.size()), 256'(0));
        chk("t5b_lines", 256'(hs_cyc.size()), 256'(1));

        // Flush while a full line is stalled behind a held line is ignored.
        out_ready = 0;
        hs_cyc.delete();
        exp_q.push_back(mkl(80, 8));
        exp_q.push_back(mkl(88, 8));
        for (int w = 80; w < 96; w++) begin
            drive_word(w, 4, ok);
            chk($sformatf("t5c_accept_%0d", w), 256'(ok), 256'(1));
        end
        in_valid = 0;
        flush = 1;
        #1;
        chk("t5c_in_ready", 256'(in_ready), 256'(0));
        @(posedge clk);
        #1;
        flush = 0;
        chk("t5c_hold_count", 256'(out_count), 256'(8));
        chk("t5c_hold_data", out_data, seq_line(80, 8));
        out_ready = 1;
        wait_drain("t5c_drain", 20);
        idle(4);
        chk("t5c_lines", 256'(hs_cyc.size()), 256'(2));
        mon_en = 0;

        // MSB-first 4 x 16-bit instance, then reset in the middle of a line.
        m_out_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            m_in_valid = 1;
            m_in_data  = 16'(i);
            #1;
            chk($sformatf("t6_in_ready_%0d", i), 256'(m_in_ready), 256'(1));
            @(posedge clk);
            #1;
        end
        m_in_valid = 0;
        for (int c = 0; c < 6 && !m_out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_valid", 256'(m_out_valid), 256'(1));
        chk("t6_data", 256'(m_out_data), 256'(64'h0001_0002_0003_0004));
        chk("t6_count", 256'(m_out_count), 256'(4));
        for (int i = 5; i <= 6; i++) begin
            m_in_valid = 1;
            m_in_data  = 16'(i);
            @(posedge clk);
            #1;
        end
        m_in_valid = 0;
        chk("t6_held_valid", 256'(m_out_valid), 256'(1));
        #2;
        rst_m = 1;
        #1;
        chk("t6_rst_valid", 256'(m_out_valid), 256'(0));
        chk("t6_rst_data", 256'(m_out_data), 256'(0));
        chk("t6_rst_count", 256'(m_out_count), 256'(0));
        @(posedge clk);
        #1;
        rst_m = 0;
        m_out_ready = 1;
        for (int i = 7; i <= 10; i++) begin
            m_in_valid = 1;
            m_in_data  = 16'(i);
            @(posedge clk);
            #1;
        end
        m_in_valid = 0;
        for (int c = 0; c < 6 && !m_out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_clean_valid", 256'(m_out_valid), 256'(1));
        chk("t6_clean_data", 256'(m_out_data), 256'(64'h0007_0008_0009_000a));
        chk("t6_clean_count", 256'(m_out_count), 256'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
